reg_file_2r1w: RTL and testbench
================================

// Module: reg_file_2r1w
// PURPOSE
//  General-purpose register file for the single-cycle CPU datapath. Provides
//  two combinational read ports (rs, rt) and one synchronous write port.
//  Rd2 feeds the ALU-B source 2:1 32-bit mux (register vs. immediate).
//  Rd1 drives ALU-A directly. Register 0 is hardwired to zero.
// PARAMETERS
//  WIDTH   32  data width of each register, in bits
//  DEPTH   32  number of registers; address width is AW = $clog2(DEPTH) = 5
//  BYPASS  1   1: a read of the register being written this cycle returns Wd
//              (write-to-read forwarding); 0: it returns the stored value
// PORTS
//  Clk   in   1      clock; all state changes on the rising edge
//  Rst   in   1      synchronous reset, active-high
//  We    in   1      write enable
//  Wa    in   AW     write address
//  Wd    in   WIDTH  write data
//  Ra1   in   AW     read address, port 1 (rs)
//  Ra2   in   AW     read address, port 2 (rt)
//  Rd1   out  WIDTH  read data, port 1
//  Rd2   out  WIDTH  read data, port 2
// BEHAVIOUR
//  - Interface: one clock, Clk. Reset Rst is synchronous and active-high.
//  - Reset: when Rst=1 at a rising Clk edge, all registers 1..DEPTH-1 become 0.
//    Rst has priority over We in that cycle; the write is dropped.
//  - Outputs are combinational. While the array is zero after reset, Rd1 and Rd2
//    read 0. If BYPASS=1, forwarding still applies during reset cycles.
//  - Write: at a rising Clk edge with Rst=0, We=1 and Wa!=0, store Wd in reg[Wa].
//    The new value is visible through the array on the next cycle.
//    Latency is 1 edge.
//  - Register 0: writes with Wa=0 are ignored. Ra1=0 and Ra2=0 always return 0,
//    including when We=1, Wa=0 and Wd!=0; bypass never applies to address 0.
//  - Read: Rdn = (Ran==0) ? 0 :
//      (BYPASS && We && Wa==Ran) ? Wd : reg[Ran].
//    The read is pure combinational, with no clock latency.
//  - Both ports may read the same address at once; both return the same value.
//  - Only one write per cycle, so there is no write/write conflict.
//  - Out-of-range addresses (DEPTH not a power of 2): the read returns 0 and
//    the write is ignored.
//  - X-safety: with We=0, Wa and Wd values have no effect on state.
//  - Reset mid-operation: asserting Rst during a write cycle zeroes the whole
//    array, including the target. The first write after Rst deasserts behaves
//    normally.
//  - No state machine. State is the DEPTH-1 register array only.
// TESTING
//  1. Rst=1 for 2 edges, then sweep Ra1/Ra2 over 0..31 -> Rd1=Rd2=32'h0
//     for every address.
//  2. We=1, Wa=5, Wd=32'hDEADBEEF, one edge, then We=0, Ra1=5, Ra2=5
//     -> Rd1=Rd2=32'hDEADBEEF.
//  3. We=1, Wa=0, Wd=32'hFFFFFFFF, one edge; Ra1=0 during and after the edge
//     -> Rd1=0 at all times.
//  4. BYPASS=1, reg[7]=32'h1, then We=1, Wa=7, Wd=32'h22, Ra2=7 before the edge
//     -> Rd2=32'h22 combinationally. With BYPASS=0, the same stimulus gives
//     Rd2=32'h1 before the edge and 32'h22 after it.
//  5. reg[3]=32'hA5A5A5A5, then Rst=1 with We=1, Wa=3, Wd=32'h5 on the same edge,
//     then Rst=0 and We=0 -> Ra1=3 returns 32'h0.
//  6. Random write/read sequence (1000 cycles) against a reference array model
//     -> Rd1/Rd2 match the model every cycle, and reg 0 reads 0 throughout.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w
// General-purpose register file for the single-cycle CPU datapath.
// Two combinational read ports (rs, rt) and one synchronous write port.
// Register 0 is hardwired to zero and is not stored.
//
// Ports
//   Clk   in   1      clock, all state changes on the rising edge
//   Rst   in   1      synchronous reset, active-high (clears regs 1..DEPTH-1)
//   We    in   1      write enable
//   Wa    in   AW     write address
//   Wd    in   WIDTH  write data
//   Ra1   in   AW     read address, port 1 (rs, feeds ALU-A)
//   Ra2   in   AW     read address, port 2 (rt, feeds ALU-B source mux)
//   Rd1   out  WIDTH  read data, port 1 (combinational)
//   Rd2   out  WIDTH  read data, port 2 (combinational)
// ---------------------------------------------------------------------------
module reg_file_2r1w #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             We,
    input  logic [AW-1:0]    Wa,
    input  logic [WIDTH-1:0] Wd,
    input  logic [AW-1:0]    Ra1,
    input  logic [AW-1:0]    Ra2,
    output logic [WIDTH-1:0] Rd1,
    output logic [WIDTH-1:0] Rd2
);

    // Storage for registers 1..DEPTH-1; register 0 has no flops.
    logic [WIDTH-1:0] regs [1:DEPTH-1];

    // An address is usable only if non-zero and inside the populated range
    // (matters when DEPTH is not a power of two).
    function automatic logic addr_live(input logic [AW-1:0] addr);
        return (addr != '0) && (32'(addr) < DEPTH);
    endfunction

    // Write port: reset wins over a same-edge write; Wa=0 and out-of-range
    // addresses match no entry, so they are dropped naturally.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (We) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (Wa == AW'(i)) begin
                    regs[i] <= Wd;
                end
            end
        end
    end

    // Read mux built as a priority-free decode so no variable index can
    // run outside the populated array.
    function automatic logic [WIDTH-1:0] array_read(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                val = regs[i];
            end
        end
        return val;
    endfunction

    // Full read path: zero register, optional write forwarding, then array.
    // Forwarding is not qualified by Rst, so it still applies in reset cycles.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        if (addr_live(addr)) begin
            if (BYPASS && We && (Wa == addr)) begin
                val = Wd;
            end else begin
                val = array_read(addr);
            end
        end
        return val;
    endfunction

    // Read port 1 (rs)
    always_comb begin
        Rd1 = '0;
        Rd1 = read_port(Ra1);
    end

    // Read port 2 (rt)
    always_comb begin
        Rd2 = '0;
        Rd2 = read_port(Ra2);
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned ODD_DEPTH = 20;

    logic             clk;
    logic             rst;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [WIDTH-1:0] rd1_b, rd2_b;
    logic [WIDTH-1:0] rd1_n, rd2_n;
    logic [WIDTH-1:0] rd1_o, rd2_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] mdl [0:31];

    // Forwarding variant
    reg_file_2r1w #(.WIDTH(WIDTH), .DEPTH(32), .BYPASS(1'b1)) u_byp (
        .Clk(clk), .Rst(rst), .We(we), .Wa(wa), .Wd(wd),
        .Ra1(ra1), .Ra2(ra2), .Rd1(rd1_b), .Rd2(rd2_b)
    );

    // Non-forwarding variant
    reg_file_2r1w #(.WIDTH(WIDTH), .DEPTH(32), .BYPASS(1'b0)) u_nobyp (
        .Clk(clk), .Rst(rst), .We(we), .Wa(wa), .Wd(wd),
        .Ra1(ra1), .Ra2(ra2), .Rd1(rd1_n), .Rd2(rd2_n)
    );

    // Non-power-of-two depth variant
    reg_file_2r1w #(.WIDTH(WIDTH), .DEPTH(ODD_DEPTH), .BYPASS(1'b1)) u_odd (
        .Clk(clk), .Rst(rst), .We(we), .Wa(wa), .Wd(wd),
        .Ra1(ra1), .Ra2(ra2), .Rd1(rd1_o), .Rd2(rd2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] e1, e2, e1n, e1o;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

        // 1. reset for two edges, sweep all addresses
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = AW'(i); ra2 = AW'(31 - i);
            #1;
            check("rst_rd1", rd1_b, '0);
            check("rst_rd2", rd2_b, '0);
            check("rst_rd1_nobyp", rd1_n, '0);
        end

        // 2. basic write then read on both ports
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick();
        we = 1'b0; wa = 5'd9; wd = 32'h0BAD_F00D; ra1 = 5'd5; ra2 = 5'd5;
        #1;
        check("wr5_rd1", rd1_b, 32'hDEADBEEF);
        check("wr5_rd2", rd2_b, 32'hDEADBEEF);
        check("wr5_rd1_nobyp", rd1_n, 32'hDEADBEEF);

        // 3. register 0 is immune to writes and bypass
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
        #1;
        check("r0_during_rd1", rd1_b, '0);
        check("r0_during_rd2", rd2_b, '0);
        tick();
        check("r0_after_edge", rd1_b, '0);
        we = 1'b0;
        #1;
        check("r0_after_we0", rd1_b, '0);
        check("r0_after_we0_nobyp", rd1_n, '0);

        // 4. forwarding vs. stored value
        we = 1'b1; wa = 5'd7; wd = 32'h1;
        tick();
        wd = 32'h22; ra2 = 5'd7;
        #1;
        check("byp_rd2", rd2_b, 32'h22);
        check("nobyp_before", rd2_n, 32'h1);
        tick();
        we = 1'b0;
        #1;
        check("byp_after", rd2_b, 32'h22);
        check("nobyp_after", rd2_n, 32'h22);

        // 5. reset beats a same-edge write; forwarding during reset
        we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5;
        tick();
        rst = 1'b1; wd = 32'h5; ra1 = 5'd3; ra2 = 5'd5;
        #1;
        check("byp_in_rst", rd1_b, 32'h5);
        check("nobyp_in_rst", rd1_n, 32'hA5A5A5A5);
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        check("rst_wins_r3", rd1_b, '0);
        check("rst_clears_r5", rd2_b, '0);
        check("rst_wins_r3_nobyp", rd1_n, '0);
        we = 1'b1; wa = 5'd3; wd = 32'h77;
        tick();
        we = 1'b0;
        #1;
        check("first_wr_after_rst", rd1_n, 32'h77);

        // 6. We=0 leaves state alone
        we = 1'b0; wa = 5'd9; wd = 32'h123; ra1 = 5'd9;
        tick();
        check("we0_no_write", rd1_b, '0);

        // 7. non-power-of-two depth: top entry works, beyond range reads 0
        we = 1'b1; wa = 5'd19; wd = 32'hCAFE0019;
        tick();
        wa = 5'd20; wd = 32'hCAFE0020;
        tick();
        we = 1'b0; ra1 = 5'd19; ra2 = 5'd20;
        #1;
        check("odd_top", rd1_o, 32'hCAFE0019);
        check("odd_oor", rd2_o, '0);
        check("full_r20", rd2_b, 32'hCAFE0020);

        // 8. pseudo-random sequence against a reference array
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        for (int c = 0; c < 1000; c++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = AW'($urandom_range(0, 31));
            wd  = WIDTH'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            #1;
            e1  = (ra1 == 0) ? '0 : (we && wa == ra1) ? wd : mdl[ra1];
            e2  = (ra2 == 0) ? '0 : (we && wa == ra2) ? wd : mdl[ra2];
            e1n = (ra1 == 0) ? '0 : mdl[ra1];
            e1o = (32'(ra1) >= ODD_DEPTH) ? '0 : e1;
            check("rnd_rd1", rd1_b, e1);
            check("rnd_rd2", rd2_b, e2);
            check("rnd_rd1_nobyp", rd1_n, e1n);
            check("rnd_rd1_odd", rd1_o, e1o);
            tick();
            if (we && wa != 0) mdl[wa] = wd;
        end
        ra1 = 5'd0; we = 1'b0;
        #1;
        check("rnd_r0_end", rd1_b, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
